// File: rtl/iec_sd_responder.sv
// Sector server for the iec_drive complex: grants one drive at a time (round-robin) and
// streams its 512-byte blocks between the drive buffer and a byte-wide image memory.
module iec_sd_responder #(
  parameter int DRIVES = 2,
  parameter int MEM_AW = 27,
  localparam int NDR = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES)
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       sd_lba       [NDR],
  input  logic [5:0]        sd_blk_cnt   [NDR],
  input  logic [NDR-1:0]    sd_rd,
  input  logic [NDR-1:0]    sd_wr,
  output logic [NDR-1:0]    sd_ack,
  output logic [13:0]       sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din  [NDR],
  output logic              sd_buff_wr,
  input  logic [NDR-1:0]    img_readonly,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_RD_PUT, S_WR_ADDR, S_WR_LAT, S_WR_REQ, S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  sel_reg, rr_reg;
  logic [31:0] lba_reg;
  logic [13:0] last_reg, off_reg;
  logic [7:0]  rdata_reg, wdata_reg;

  // Per-drive inputs widened to four slots so a 2-bit selector indexes them for any NDR.
  logic [31:0] lba_pad [4];
  logic [5:0]  cnt_pad [4];
  logic [7:0]  din_pad [4];
  logic [3:0]  rd_pad, wr_pad, ro_pad, req_pad;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pad
      if (gi < NDR) begin : g_on
        assign lba_pad[gi] = sd_lba[gi];
        assign cnt_pad[gi] = sd_blk_cnt[gi];
        assign din_pad[gi] = sd_buff_din[gi];
        assign rd_pad[gi]  = sd_rd[gi];
        assign wr_pad[gi]  = sd_wr[gi];
        assign ro_pad[gi]  = img_readonly[gi];
      end else begin : g_off
        assign lba_pad[gi] = '0;
        assign cnt_pad[gi] = '0;
        assign din_pad[gi] = '0;
        assign rd_pad[gi]  = 1'b0;
        assign wr_pad[gi]  = 1'b0;
        assign ro_pad[gi]  = 1'b0;
      end
    end
  endgenerate

  assign req_pad = rd_pad | wr_pad;

  // Scan from the far end back toward rr+1 so the drive right after rr wins.
  logic       grant_vld;
  logic [1:0] grant_idx;
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    for (int k = NDR; k >= 1; k--) begin
      if (req_pad[2'((int'(rr_reg) + k) % NDR)]) begin
        grant_vld = 1'b1;
        grant_idx = 2'((int'(rr_reg) + k) % NDR);
      end
    end
  end

  logic [5:0] cnt_g;
  logic [4:0] nblk_m1;
  logic       ro_sel, is_last;
  assign cnt_g   = cnt_pad[grant_idx];
  assign nblk_m1 = cnt_g[5] ? 5'd31 : cnt_g[4:0];
  assign ro_sel  = ro_pad[sel_reg];
  assign is_last = (off_reg == last_reg);

  always_ff @(posedge clk_sys) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sel_reg   <= 2'd0;
      rr_reg    <= 2'd0;
      lba_reg   <= 32'd0;
      last_reg  <= 14'd0;
      off_reg   <= 14'd0;
      rdata_reg <= 8'd0;
      wdata_reg <= 8'd0;
    end else begin
      case (state_reg)
        S_IDLE: if (grant_vld) begin
          sel_reg  <= grant_idx;
          lba_reg  <= lba_pad[grant_idx];
          last_reg <= {nblk_m1, 9'h1FF};
          off_reg  <= 14'd0;
        end
        S_RD_WAIT: if (mem_ack) rdata_reg <= mem_rdata;
        S_RD_PUT:  off_reg <= off_reg + 14'd1;
        S_WR_LAT:  wdata_reg <= din_pad[sel_reg];
        S_WR_REQ:  if (mem_ack || ro_sel) off_reg <= off_reg + 14'd1;
        S_DONE:    rr_reg <= sel_reg;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (grant_vld) state_next = wr_pad[grant_idx] ? S_WR_ADDR : S_RD_REQ;
      S_RD_REQ:  state_next = S_RD_WAIT;
      S_RD_WAIT: if (mem_ack) state_next = S_RD_PUT;
      S_RD_PUT:  state_next = is_last ? S_DONE : S_RD_REQ;
      S_WR_ADDR: state_next = S_WR_LAT;
      S_WR_LAT:  state_next = S_WR_REQ;
      // A write-protected image skips the memory handshake but keeps the buffer walk.
      S_WR_REQ:  if (mem_ack || ro_sel) state_next = is_last ? S_DONE : S_WR_ADDR;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  logic ack_on;
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    sd_buff_wr = 1'b0;
    ack_on     = 1'b1;
    case (state_reg)
      S_IDLE, S_DONE:      ack_on = 1'b0;
      S_RD_REQ, S_RD_WAIT: mem_req = 1'b1;
      S_RD_PUT:            sd_buff_wr = 1'b1;
      S_WR_REQ: begin
        mem_req = !ro_sel;
        mem_we  = !ro_sel;
      end
      default: ;
    endcase
  end

  generate
    for (gi = 0; gi < NDR; gi++) begin : g_ack
      assign sd_ack[gi] = ack_on && (sel_reg == 2'(gi));
    end
  endgenerate

  assign sd_buff_addr = off_reg;
  assign sd_buff_dout = rdata_reg;
  assign mem_wdata    = wdata_reg;
  assign mem_addr     = MEM_AW'({lba_reg, 9'd0}) + MEM_AW'(off_reg);

endmodule

// File: tb/tb_iec_sd_responder.sv
// Randomized bench for iec_sd_responder: a drive/memory environment plus an address-arithmetic
// reference for the expected buffer strobes and memory operations.
module tb_iec_sd_responder;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] sd_lba [2];
  logic [5:0]  sd_blk_cnt [2];
  logic [1:0]  sd_rd, sd_wr, sd_ack, img_readonly;
  logic [13:0] sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din [2];
  logic        sd_buff_wr;
  logic [26:0] mem_addr;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_wdata, mem_rdata;

  iec_sd_responder #(.DRIVES(2), .MEM_AW(27)) dut (
    .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
    .img_readonly(img_readonly), .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk_sys = ~clk_sys;

  int vectors, miscompares;
  int max_delay, mem_mode;
  bit cur_wr;
  logic [7:0]  bufs [2][16384];
  logic [13:0] st_addr[$];
  logic [7:0]  st_data[$];
  logic [26:0] rq_addr[$];
  logic        rq_we[$];
  logic [7:0]  rq_data[$];
  int          grant_q[$];
  int          ack_rise [2];
  int          multi_ack, stray_req, bad_strobe;
  bit          pending;
  int          dly;
  logic [26:0] lat_addr;
  logic [13:0] addr_q;
  logic [1:0]  ack_prev;

  function automatic logic [7:0] mem_fn(input logic [26:0] a);
    return (mem_mode == 0) ? a[7:0] : (a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A);
  endfunction

  function automatic logic [26:0] exp_addr(input logic [31:0] lba, input int i);
    logic [63:0] s;
    s = {32'd0, lba} * 64'd512 + 64'(i);
    return s[26:0];
  endfunction

  // Environment: monitors outputs, models the drive buffer read latency and the memory.
  initial begin
    pending = 0; dly = 0; addr_q = '0; ack_prev = '0; lat_addr = '0;
    mem_ack = 1'b0; mem_rdata = 8'd0;
    multi_ack = 0; stray_req = 0; bad_strobe = 0; ack_rise[0] = 0; ack_rise[1] = 0;
    for (int d = 0; d < 2; d++) begin
      sd_buff_din[d] = 8'd0;
      for (int i = 0; i < 16384; i++) bufs[d][i] = 8'd0;
    end
    forever begin
      @(negedge clk_sys);
      if (sd_buff_wr) begin
        st_addr.push_back(sd_buff_addr);
        st_data.push_back(sd_buff_dout);
        if (cur_wr) bad_strobe++;
      end
      if ($countones(sd_ack) > 1) multi_ack++;
      if (mem_req && sd_ack == 2'b00) stray_req++;
      for (int d = 0; d < 2; d++)
        if (sd_ack[d] && !ack_prev[d]) begin
          ack_rise[d]++;
          grant_q.push_back(d);
        end
      ack_prev = sd_ack;
      for (int d = 0; d < 2; d++) sd_buff_din[d] = bufs[d][addr_q];
      addr_q = sd_buff_addr;
      mem_ack = 1'b0;
      if (pending) begin
        if (!mem_req) pending = 0;
        else if (dly == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem_fn(lat_addr);
          pending = 0;
        end else dly--;
      end else if (mem_req) begin
        pending = 1;
        dly = int'($urandom_range(0, max_delay));
        lat_addr = mem_addr;
        rq_addr.push_back(mem_addr);
        rq_we.push_back(mem_we);
        rq_data.push_back(mem_wdata);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic raise(input int d, input bit rd, input bit wr, input logic [31:0] lba,
                       input logic [5:0] cnt);
    @(negedge clk_sys);
    sd_lba[d] = lba;
    sd_blk_cnt[d] = cnt;
    if (rd) sd_rd[d] = 1'b1;
    if (wr) sd_wr[d] = 1'b1;
  endtask

  // Drives drop their request as soon as they see their ack.
  task automatic wait_xfer(input int d, input int bound, output int lat, output bit ok);
    int n;
    lat = 0; ok = 0; n = 0;
    while (!sd_ack[d] && lat < bound) begin
      @(negedge clk_sys); lat++;
      sd_rd = sd_rd & ~sd_ack; sd_wr = sd_wr & ~sd_ack;
    end
    if (!sd_ack[d]) return;
    while (sd_ack[d] && n < 40000) begin
      @(negedge clk_sys); n++;
      sd_rd = sd_rd & ~sd_ack; sd_wr = sd_wr & ~sd_ack;
    end
    ok = !sd_ack[d];
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    vectors++;
    if ({sd_ack, mem_req, mem_we, sd_buff_wr, sd_buff_addr, sd_buff_dout, mem_addr, mem_wdata} !== 62'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ack=%b req=%b we=%b wr=%b addr=%h dout=%h maddr=%h wdata=%h, want all 0",
               sd_ack, mem_req, mem_we, sd_buff_wr, sd_buff_addr, sd_buff_dout, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    vectors++;
    if ({sd_ack, mem_req, sd_buff_wr} !== 4'd0) begin
      miscompares++;
      $display("FAIL idle_quiet: got ack=%b req=%b wr=%b, want 0", sd_ack, mem_req, sd_buff_wr);
    end
  endtask

  task automatic test_read_single();
    int lat, sb, rb, r0, r1, nbad, first; bit ok;
    mem_mode = 0; max_delay = 0; cur_wr = 0;
    sb = st_addr.size(); rb = rq_addr.size(); r0 = ack_rise[0]; r1 = ack_rise[1];
    raise(0, 1, 0, 32'd3, 6'd0);
    wait_xfer(0, 20, lat, ok);
    $display("xfer drive=0 rd lba=3 blocks=1 strobes=%0d memops=%0d", st_addr.size() - sb, rq_addr.size() - rb);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rd1_done: got %0d want 1", ok); end
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL rd1_ack_latency: got %0d want 1", lat); end
    vectors++; if (st_addr.size() - sb != 512) begin miscompares++; $display("FAIL rd1_strobes: got %0d want 512", st_addr.size() - sb); end
    vectors++; if (ack_rise[0] - r0 != 1 || ack_rise[1] - r1 != 0) begin
      miscompares++; $display("FAIL rd1_ack_pulses: got d0=%0d d1=%0d want 1/0", ack_rise[0] - r0, ack_rise[1] - r1); end
    nbad = 0; first = -1;
    for (int i = 0; i < 512 && sb + i < st_addr.size(); i++)
      if (st_addr[sb+i] !== 14'(i) || st_data[sb+i] !== 8'(i)) begin nbad++; if (first < 0) first = i; end
    vectors++; if (nbad != 0) begin miscompares++; $display("FAIL rd1_strobe_data: %0d bad bytes first at %0d, want 0", nbad, first); end
    nbad = 0; first = -1;
    for (int i = 0; i < 512 && rb + i < rq_addr.size(); i++)
      if (rq_addr[rb+i] !== 27'h600 + 27'(i) || rq_we[rb+i] !== 1'b0) begin nbad++; if (first < 0) first = i; end
    vectors++; if (nbad != 0 || rq_addr.size() - rb != 512) begin
      miscompares++; $display("FAIL rd1_mem_addr: %0d bad of %0d ops first at %0d, want 0 of 512", nbad, rq_addr.size() - rb, first); end
    vectors++; if ({sd_ack, mem_req} !== 3'd0) begin miscompares++; $display("FAIL rd1_done_quiet: got ack=%b req=%b want 0", sd_ack, mem_req); end
  endtask

  task automatic test_read_delay();
    int lat, sb, rb, nbad, first, amax; bit ok;
    mem_mode = 1; max_delay = 5; cur_wr = 0;
    sb = st_addr.size(); rb = rq_addr.size();
    raise(1, 1, 0, 32'd0, 6'd1);
    wait_xfer(1, 20, lat, ok);
    $display("xfer drive=1 rd lba=0 blocks=2 strobes=%0d memops=%0d", st_addr.size() - sb, rq_addr.size() - rb);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rd2_done: got %0d want 1", ok); end
    vectors++; if (st_addr.size() - sb != 1024) begin miscompares++; $display("FAIL rd2_strobes: got %0d want 1024", st_addr.size() - sb); end
    nbad = 0; first = -1; amax = 0;
    for (int i = 0; i < 1024 && sb + i < st_addr.size(); i++) begin
      if (int'(st_addr[sb+i]) > amax) amax = int'(st_addr[sb+i]);
      if (st_addr[sb+i] !== 14'(i) || st_data[sb+i] !== mem_fn(exp_addr(32'd0, i))) begin nbad++; if (first < 0) first = i; end
    end
    vectors++; if (nbad != 0) begin miscompares++; $display("FAIL rd2_strobe_data: %0d bad bytes first at %0d, want 0", nbad, first); end
    vectors++; if (amax != 1023) begin miscompares++; $display("FAIL rd2_max_addr: got %0d want 1023", amax); end
    vectors++; if (rq_addr.size() - rb != 1024) begin miscompares++; $display("FAIL rd2_memops: got %0d want 1024", rq_addr.size() - rb); end
  endtask

  task automatic test_write();
    int lat, sb, rb, nbad, first; bit ok;
    for (int i = 0; i < 512; i++) bufs[0][i] = ~8'(i);
    mem_mode = 0; max_delay = 2; cur_wr = 1;
    sb = st_addr.size(); rb = rq_addr.size();
    raise(0, 0, 1, 32'd2, 6'd0);
    wait_xfer(0, 20, lat, ok);
    $display("xfer drive=0 wr lba=2 blocks=1 strobes=%0d memops=%0d", st_addr.size() - sb, rq_addr.size() - rb);
    cur_wr = 0;
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL wr1_done: got %0d want 1", ok); end
    vectors++; if (rq_addr.size() - rb != 512) begin miscompares++; $display("FAIL wr1_memops: got %0d want 512", rq_addr.size() - rb); end
    nbad = 0; first = -1;
    for (int i = 0; i < 512 && rb + i < rq_addr.size(); i++)
      if (rq_addr[rb+i] !== 27'h400 + 27'(i) || rq_we[rb+i] !== 1'b1 || rq_data[rb+i] !== ~8'(i)) begin
        nbad++; if (first < 0) first = i; end
    vectors++; if (nbad != 0) begin miscompares++; $display("FAIL wr1_mem_data: %0d bad ops first at %0d, want 0", nbad, first); end
    vectors++; if (st_addr.size() - sb != 0) begin miscompares++; $display("FAIL wr1_no_strobe: got %0d want 0", st_addr.size() - sb); end
  endtask

  task automatic test_arbitration();
    int lat, sb, gb, nbad, first; bit ok;
    mem_mode = 1; max_delay = 0; cur_wr = 0;
    sb = st_addr.size(); gb = grant_q.size();
    @(negedge clk_sys);
    sd_lba[0] = 32'd5; sd_blk_cnt[0] = 6'd0;
    sd_lba[1] = 32'd9; sd_blk_cnt[1] = 6'd0;
    sd_rd = 2'b11;
    wait_xfer(0, 6000, lat, ok);
    $display("xfer drives=0,1 rd same cycle grants=%0d strobes=%0d", grant_q.size() - gb, st_addr.size() - sb);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL arb_done: got %0d want 1", ok); end
    vectors++; if (grant_q.size() - gb != 2) begin miscompares++; $display("FAIL arb_grants: got %0d want 2", grant_q.size() - gb); end
    else begin
      vectors++; if (grant_q[gb] != 1 || grant_q[gb+1] != 0) begin
        miscompares++; $display("FAIL arb_order: got %0d,%0d want 1,0", grant_q[gb], grant_q[gb+1]); end
    end
    nbad = 0; first = -1;
    for (int i = 0; i < 1024 && sb + i < st_addr.size(); i++)
      if (st_data[sb+i] !== mem_fn(exp_addr((i < 512) ? 32'd9 : 32'd5, i % 512))) begin nbad++; if (first < 0) first = i; end
    vectors++; if (nbad != 0 || st_addr.size() - sb != 1024) begin
      miscompares++; $display("FAIL arb_data: %0d bad of %0d first at %0d, want 0 of 1024", nbad, st_addr.size() - sb, first); end
  endtask

  task automatic test_readonly();
    int lat, sb, rb, r0; bit ok;
    img_readonly = 2'b01; cur_wr = 1; max_delay = 0;
    sb = st_addr.size(); rb = rq_addr.size(); r0 = ack_rise[0];
    raise(0, 0, 1, 32'd7, 6'd0);
    wait_xfer(0, 20, lat, ok);
    $display("xfer drive=0 wr readonly lba=7 blocks=1 memops=%0d", rq_addr.size() - rb);
    cur_wr = 0; img_readonly = 2'b00;
    vectors++; if (ok !== 1'b1 || lat != 1) begin miscompares++; $display("FAIL ro_ack: got done=%0d lat=%0d want 1/1", ok, lat); end
    vectors++; if (rq_addr.size() - rb != 0) begin miscompares++; $display("FAIL ro_no_req: got %0d want 0", rq_addr.size() - rb); end
    vectors++; if (ack_rise[0] - r0 != 1) begin miscompares++; $display("FAIL ro_ack_pulses: got %0d want 1", ack_rise[0] - r0); end
    vectors++; if (st_addr.size() - sb != 0) begin miscompares++; $display("FAIL ro_no_strobe: got %0d want 0", st_addr.size() - sb); end
  endtask

  task automatic test_reset_mid();
    int lat, sb, n, nbad, first; bit ok;
    mem_mode = 0; max_delay = 1; cur_wr = 0;
    sb = st_addr.size(); n = 0;
    raise(0, 1, 0, 32'd1, 6'd0);
    while (st_addr.size() - sb < 100 && n < 5000) begin
      @(negedge clk_sys); n++;
      sd_rd = sd_rd & ~sd_ack;
    end
    vectors++; if (st_addr.size() - sb < 100) begin miscompares++; $display("FAIL rst_reach100: got %0d strobes want >=100", st_addr.size() - sb); end
    reset = 1'b1;
    @(negedge clk_sys);
    vectors++;
    if ({sd_ack, mem_req, mem_we, sd_buff_wr, sd_buff_addr, sd_buff_dout, mem_addr, mem_wdata} !== 62'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got ack=%b req=%b wr=%b addr=%h dout=%h maddr=%h, want all 0",
               sd_ack, mem_req, sd_buff_wr, sd_buff_addr, sd_buff_dout, mem_addr);
    end
    $display("xfer drive=0 rd lba=1 aborted by reset after %0d strobes", st_addr.size() - sb);
    reset = 1'b0;
    @(negedge clk_sys);
    sb = st_addr.size();
    raise(0, 1, 0, 32'd1, 6'd0);
    wait_xfer(0, 20, lat, ok);
    $display("xfer drive=0 rd lba=1 blocks=1 strobes=%0d", st_addr.size() - sb);
    nbad = 0; first = -1;
    for (int i = 0; i < 512 && sb + i < st_addr.size(); i++)
      if (st_addr[sb+i] !== 14'(i) || st_data[sb+i] !== 8'(i)) begin nbad++; if (first < 0) first = i; end
    vectors++; if (ok !== 1'b1 || st_addr.size() - sb != 512 || nbad != 0) begin
      miscompares++; $display("FAIL rst_rerequest: done=%0d strobes=%0d bad=%0d want 1/512/0", ok, st_addr.size() - sb, nbad); end
  endtask

  task automatic test_random();
    int lat, sb, rb, d, nb, nbad, first; bit ok, wr, rd;
    logic [31:0] lba; logic [5:0] cnt;
    mem_mode = 1;
    for (int t = 0; t < 3; t++) begin
      d = int'($urandom % 2);
      wr = 1'($urandom % 2);
      rd = wr ? 1'($urandom % 2) : 1'b1;
      lba = (t == 0) ? 32'hFFFF_FFFF : $urandom;
      cnt = (t == 0) ? 6'd1 : 6'($urandom % 2);
      max_delay = int'($urandom % 4);
      nb = (int'(cnt) + 1) * 512;
      if (wr) for (int i = 0; i < 1024; i++) bufs[d][i] = 8'($urandom);
      cur_wr = wr;
      sb = st_addr.size(); rb = rq_addr.size();
      raise(d, rd, wr, lba, cnt);
      wait_xfer(d, 20, lat, ok);
      cur_wr = 0;
      $display("xfer drive=%0d rd=%0d wr=%0d lba=%h blocks=%0d strobes=%0d memops=%0d",
               d, rd, wr, lba, int'(cnt) + 1, st_addr.size() - sb, rq_addr.size() - rb);
      vectors++; if (ok !== 1'b1 || lat != 1) begin miscompares++; $display("FAIL rnd%0d_ack: done=%0d lat=%0d want 1/1", t, ok, lat); end
      vectors++; if (rq_addr.size() - rb != nb || st_addr.size() - sb != (wr ? 0 : nb)) begin
        miscompares++; $display("FAIL rnd%0d_counts: memops=%0d strobes=%0d want %0d/%0d", t,
                                rq_addr.size() - rb, st_addr.size() - sb, nb, wr ? 0 : nb); end
      nbad = 0; first = -1;
      for (int i = 0; i < nb && rb + i < rq_addr.size(); i++) begin
        if (rq_addr[rb+i] !== exp_addr(lba, i) || rq_we[rb+i] !== wr ||
            (wr && rq_data[rb+i] !== bufs[d][i])) begin nbad++; if (first < 0) first = i; end
        if (!wr && sb + i < st_addr.size() &&
            (st_addr[sb+i] !== 14'(i) || st_data[sb+i] !== mem_fn(exp_addr(lba, i)))) begin nbad++; if (first < 0) first = i; end
      end
      vectors++; if (nbad != 0) begin miscompares++; $display("FAIL rnd%0d_data: %0d bad first at %0d, want 0", t, nbad, first); end
    end
  endtask

  task automatic test_invariants();
    vectors++; if (multi_ack != 0) begin miscompares++; $display("FAIL inv_single_ack: got %0d cycles want 0", multi_ack); end
    vectors++; if (stray_req != 0) begin miscompares++; $display("FAIL inv_req_outside_xfer: got %0d cycles want 0", stray_req); end
    vectors++; if (bad_strobe != 0) begin miscompares++; $display("FAIL inv_no_wr_strobe: got %0d cycles want 0", bad_strobe); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; sd_rd = 2'b00; sd_wr = 2'b00; img_readonly = 2'b00;
    sd_lba[0] = 32'd0; sd_lba[1] = 32'd0; sd_blk_cnt[0] = 6'd0; sd_blk_cnt[1] = 6'd0;
    max_delay = 0; mem_mode = 0; cur_wr = 0;
    test_reset();
    test_read_single();
    test_read_delay();
    test_write();
    test_arbitration();
    test_readonly();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
